ddr_dispatch_arbiter: RTL
=========================

# ddr_dispatch_arbiter

Sequences the shared DDR dispatch path between the write queue and the read-request queue. Sits between the ddr_fifo status flags and the read/write dispatcher. It drives the dispatcher's `mode` select, gates each side's "has work" flags so only one side can pop at a time, and bounds each service burst so neither side starves. A side switch happens only after all popped commands are accepted by the DDR controller, followed by a fixed turnaround gap.

## Interface
Parameters:
- MAX_BURST, 16: max commands accepted per service burst before forced re-arbitration (1..255).
- TURN_CYCLES, 4: idle cycles between draining one side and granting the next (0..15).
- PEND_W, 4: width of the outstanding-command counter.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- has_wr_data  in  1  write-data FIFO non-empty.
- has_wr_adx  in  1  write-address FIFO non-empty.
- has_rd_req  in  1  read-request FIFO non-empty.
- get_wr_adx  in  1  write-side pop strobe from dispatcher (one per write command).
- get_rd_req  in  1  read-side pop strobe from dispatcher.
- app_en  in  1  dispatcher command valid to DDR controller.
- app_rdy  in  1  DDR controller command ready.
- mode  out  1  dispatcher select: 1 = read, 0 = write.
- wr_allow  out  1  ANDed onto has_wr_data/has_wr_adx before the dispatcher.
- rd_allow  out  1  ANDed onto has_rd_req before the dispatcher.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky; set on pending-counter underflow or overflow; cleared only by reset.

## Operation
- has_wr = has_wr_data & has_wr_adx. accept = app_en & app_rdy.
- pend counter: +1 on the active side's pop strobe, −1 on accept; pop and accept in the same cycle leave it unchanged. Underflow (accept at 0) or overflow (pop at all-ones) sets err and saturates.
- States: IDLE, WRITE, READ, DRAIN, TURN.
- IDLE:
  - has_wr only → WRITE.
  - has_rd only → READ.
  - Both → the side opposite last_side (round-robin).
  - Neither → stay in IDLE.
  - On entry to WRITE/READ: set mode; assert that side's allow; clear burst; record last_side.
- WRITE/READ: burst increments on each accept. Exit to DRAIN when the side's has_* is low, or when burst reaches MAX_BURST. The allow output drops on that transition.
- DRAIN: hold mode, both allows low. When pend==0 and app_en==0, go to TURN and load the turn counter with TURN_CYCLES. If TURN_CYCLES==0, go directly to IDLE.
- TURN: count down; go to IDLE on reaching 0.
- mode changes only on the IDLE→WRITE or IDLE→READ transition. It is never changed while pend≠0.
- At most one of wr_allow and rd_allow is high in any cycle.

## Timing
- All outputs registered.
- Reset values: mode=0, wr_allow=0, rd_allow=0, busy=0, err=0. Also state=IDLE, pend=0, burst=0, last_side=read (so write wins the first contention).
- Grant latency: has_* sampled high in IDLE gives allow high on the next edge.
- Burst limit: the cycle of the MAX_BURST-th accept registers allow low on the next edge. The dispatcher may pop in that same cycle; the pop is counted in pend and drained.
- Minimum switch gap: 1 (DRAIN, pend already 0) + TURN_CYCLES + 1 (IDLE) cycles from allow falling to the other side's allow rising.
- Reset mid-operation: all state returns to reset values on the next edge. pend is discarded.

## Structure
- Shared package (ddr_dispatch_pkg): state enum, READ_MODE=1/WRITE_MODE=0 constants, side encoding for last_side.
- Single flat module; no sub-module. The pend counter is small enough to stay inline.

## Test plan
- **Write-only burst:** has_wr high, 20 commands, app_rdy=1, MAX_BURST=16. Expect wr_allow high for exactly 16 accepts, then DRAIN, 4 TURN cycles, and a re-grant to WRITE with mode=0 throughout.
- **Contention:** has_wr and has_rd both high from reset. Expect WRITE first (mode=0), then READ (mode=1 after the gap), alternating each burst. Allows are never simultaneously high.
- **Drain with stalls:** 3 pops issued, app_rdy held low 10 cycles after allow drops. Expect the state to stay in DRAIN and mode to hold until the 3rd accept, then TURN.
- **Empty exit:** has_rd drops after 5 read accepts. Expect READ→DRAIN→TURN→IDLE, busy low after the gap, and burst=5 never reaching the limit.
- **Error:** accept with pend=0. Expect err=1 next cycle, held until reset. pend stays 0.
- **Reset mid-burst:** reset pulsed during WRITE with pend=2. Expect all outputs at reset values next cycle, and a clean re-grant afterwards.

Source files
------------

// File: rtl/ddr_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_dispatch_pkg
//  Purpose  : Shared state encoding, mode and side constants for the DDR
//             dispatch arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package ddr_dispatch_pkg;

    // Arbiter FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_TURN  = 3'd4;

    // Dispatcher mode select values
    localparam logic READ_MODE  = 1'b1;
    localparam logic WRITE_MODE = 1'b0;

    // Encoding of the most recently granted side (round-robin memory)
    localparam logic SIDE_WRITE = 1'b0;
    localparam logic SIDE_READ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ddr_dispatch_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_dispatch_arbiter_if
//  Purpose  : Bundle of FIFO status, dispatcher strobes, DDR handshake and
//             arbiter outputs shared between the arbiter and its neighbours.
//  Revision : 1.0  initial release
// ============================================================================
interface ddr_dispatch_arbiter_if;

    logic has_wr_data;
    logic has_wr_adx;
    logic has_rd_req;
    logic get_wr_adx;
    logic get_rd_req;
    logic app_en;
    logic app_rdy;
    logic mode;
    logic wr_allow;
    logic rd_allow;
    logic busy;
    logic err;

    // Environment side: FIFOs, dispatcher and DDR controller
    modport master (
        output has_wr_data, has_wr_adx, has_rd_req,
        output get_wr_adx, get_rd_req, app_en, app_rdy,
        input  mode, wr_allow, rd_allow, busy, err
    );

    // Arbiter side
    modport slave (
        input  has_wr_data, has_wr_adx, has_rd_req,
        input  get_wr_adx, get_rd_req, app_en, app_rdy,
        output mode, wr_allow, rd_allow, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/ddr_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_dispatch_arbiter
//  Purpose  : Round-robin arbiter for the shared DDR dispatch path. Grants
//             bounded bursts to the write or read queue, drains outstanding
//             commands before switching, then inserts a turnaround gap.
//  Revision : 1.0  initial release
// ============================================================================
module ddr_dispatch_arbiter
    import ddr_dispatch_pkg::*;
#(
    parameter int MAX_BURST   = 16,
    parameter int TURN_CYCLES = 4,
    parameter int PEND_W      = 4
) (
    input wire clk,
    input wire reset,
    ddr_dispatch_arbiter_if.slave arb_if
);

    localparam logic [7:0]        c_BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [3:0]        c_TURN_LOAD  = 4'(TURN_CYCLES);
    localparam logic [PEND_W-1:0] c_PEND_MAX   = {PEND_W{1'b1}};

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [PEND_W-1:0] r_pend;
    logic [7:0]        r_burst;
    logic [3:0]        r_turn;
    logic              r_last_side;
    logic              r_mode;
    logic              r_wr_allow;
    logic              r_rd_allow;
    logic              r_busy;
    logic              r_err;

    logic w_has_wr;
    logic w_has_rd;
    logic w_accept;
    logic w_pop;
    logic w_burst_last;

    assign w_has_wr     = arb_if.has_wr_data & arb_if.has_wr_adx;
    assign w_has_rd     = arb_if.has_rd_req;
    assign w_accept     = arb_if.app_en & arb_if.app_rdy;
    // Pops are attributed to the side currently selected by mode, which also
    // covers the pop that may land in the final cycle of a burst.
    assign w_pop        = (r_mode == READ_MODE) ? arb_if.get_rd_req : arb_if.get_wr_adx;
    // The MAX_BURST-th accept ends the burst in the same cycle it occurs.
    assign w_burst_last = w_accept && (r_burst == c_BURST_LAST);

    // Next-state selection: round-robin grant, burst end, drain, turnaround
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_has_wr && w_has_rd) begin
                    w_state_nxt = (r_last_side == SIDE_READ) ? ST_WRITE : ST_READ;
                end else if (w_has_wr) begin
                    w_state_nxt = ST_WRITE;
                end else if (w_has_rd) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_WRITE: if (!w_has_wr || w_burst_last) w_state_nxt = ST_DRAIN;
            ST_READ:  if (!w_has_rd || w_burst_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if ((r_pend == '0) && !arb_if.app_en) begin
                    w_state_nxt = (TURN_CYCLES == 0) ? ST_IDLE : ST_TURN;
                end
            end
            ST_TURN:  if (r_turn <= 4'd1) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus registered allow/busy outputs decoded from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wr_allow <= 1'b0;
            r_rd_allow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_allow <= (w_state_nxt == ST_WRITE);
            r_rd_allow <= (w_state_nxt == ST_READ);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Mode and round-robin memory change only when a grant is issued from IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= WRITE_MODE;
            r_last_side <= SIDE_READ;
        end else if (r_state == ST_IDLE) begin
            if (w_state_nxt == ST_WRITE) begin
                r_mode      <= WRITE_MODE;
                r_last_side <= SIDE_WRITE;
            end else if (w_state_nxt == ST_READ) begin
                r_mode      <= READ_MODE;
                r_last_side <= SIDE_READ;
            end
        end
    end

    // Burst accept counter, cleared while waiting for the next grant
    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_IDLE)) begin
            r_burst <= '0;
        end else if (((r_state == ST_WRITE) || (r_state == ST_READ)) && w_accept) begin
            r_burst <= r_burst + 8'd1;
        end
    end

    // Turnaround countdown, loaded when the drain completes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_turn <= '0;
        end else if ((r_state == ST_DRAIN) && (w_state_nxt == ST_TURN)) begin
            r_turn <= c_TURN_LOAD;
        end else if ((r_state == ST_TURN) && (r_turn != '0)) begin
            r_turn <= r_turn - 4'd1;
        end
    end

    // Outstanding-command counter with saturation and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_err  <= 1'b0;
        end else if (w_pop && !w_accept) begin
            if (r_pend == c_PEND_MAX) r_err  <= 1'b1;
            else                      r_pend <= r_pend + 1'b1;
        end else if (!w_pop && w_accept) begin
            if (r_pend == '0)         r_err  <= 1'b1;
            else                      r_pend <= r_pend - 1'b1;
        end
    end

    assign arb_if.mode     = r_mode;
    assign arb_if.wr_allow = r_wr_allow;
    assign arb_if.rd_allow = r_rd_allow;
    assign arb_if.busy     = r_busy;
    assign arb_if.err      = r_err;

endmodule
`default_nettype wire
